// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: register map, field positions,
// FIFO entry layout and a saturating counter helper.
package uart_pkg;

    typedef enum logic [1:0] {
        UART_RX_DATA   = 2'd0,
        UART_RX_STATUS = 2'd1,
        UART_RX_CTRL   = 2'd2,
        UART_RX_ERRCNT = 2'd3
    } uart_rx_reg_e;

    localparam int unsigned ENTRY_W = 11;

    localparam int unsigned DATA_EMPTY    = 31;
    localparam int unsigned ST_NOT_EMPTY  = 0;
    localparam int unsigned ST_FULL       = 1;
    localparam int unsigned ST_OVERRUN    = 2;
    localparam int unsigned ST_LEVEL_LSB  = 4;
    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_IRQ_EN   = 1;
    localparam int unsigned CTRL_DROP_BAD = 2;
    localparam int unsigned CTRL_CLEAR    = 3;

    function automatic logic [7:0] sat_inc(input logic [7:0] c, input logic inc);
        return (inc && c != 8'hFF) ? c + 8'd1 : c;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Register bus between the system and the UART receive controller.
interface uart_rx_ctrl_if;
    logic        sel;
    logic        wr;
    logic        rd;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (output sel, wr, rd, addr, wdata, input rdata, irq);
    modport slave  (input sel, wr, rd, addr, wdata, output rdata, irq);
endinterface

// File: rtl/uart_rx_fifo.sv
// Synchronous DEPTH x ENTRY_W FIFO with wrap-bit pointers; a push into a full
// FIFO is accepted when a pop happens in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] din,
    output logic [ENTRY_W-1:0] dout,
    output logic               empty,
    output logic               full,
    output logic [AW:0]        level
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign dout    = mem[rd_ptr[AW-1:0]];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive controller: frame edge detect, error statistics, receive FIFO and a
// four-register bus slave with a level interrupt.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           rx_data,
    input  logic                 rx_ready,
    input  logic                 rx_err_det,
    input  logic                 rx_err_cor,
    input  logic                 rx_par_err,
    output logic                 rx_rst,
    uart_rx_ctrl_if.slave        bus
);

    logic                     enable, irq_en, drop_bad, overrun, ready_q;
    logic [7:0]               cnt_cor, cnt_unc, cnt_drp;
    logic [ENTRY_W-1:0]       fifo_dout;
    logic                     empty, full;
    logic [$clog2(DEPTH):0]   level;
    logic                     frame_evt, bad, discard, ovf, push, pop, clear, ctrl_wr, rd_en;
    logic [31:0]              rd_mux;

    assign rx_rst    = ~enable;
    assign frame_evt = rx_ready & ~ready_q;
    assign bad       = rx_err_det & ~rx_err_cor;
    assign rd_en     = bus.sel & bus.rd;
    assign ctrl_wr   = bus.sel & bus.wr & (bus.addr == UART_RX_CTRL);
    assign clear     = ctrl_wr & bus.wdata[CTRL_CLEAR];
    assign pop       = rd_en & (bus.addr == UART_RX_DATA) & ~empty;
    assign discard   = drop_bad & bad;
    // A pop in the same cycle frees the slot, so only a full FIFO without a pop overflows.
    assign ovf       = frame_evt & ~discard & full & ~pop;
    assign push      = frame_evt & ~discard & ~ovf;
    assign bus.irq   = irq_en & (~empty | overrun);

    uart_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({rx_par_err, rx_err_cor, rx_err_det, rx_data}),
        .dout  (fifo_dout),
        .empty (empty),
        .full  (full),
        .level (level)
    );

    always_comb begin
        rd_mux = '0;
        case (bus.addr)
            UART_RX_DATA: begin
                if (empty) rd_mux[DATA_EMPTY] = 1'b1;
                else       rd_mux[ENTRY_W-1:0] = fifo_dout;
            end
            UART_RX_STATUS: begin
                rd_mux[ST_NOT_EMPTY]         = ~empty;
                rd_mux[ST_FULL]              = full;
                rd_mux[ST_OVERRUN]           = overrun;
                rd_mux[ST_LEVEL_LSB +: 4]    = 4'(level);
            end
            UART_RX_CTRL: begin
                rd_mux[CTRL_EN]       = enable;
                rd_mux[CTRL_IRQ_EN]   = irq_en;
                rd_mux[CTRL_DROP_BAD] = drop_bad;
            end
            default: rd_mux = {8'h00, cnt_drp, cnt_unc, cnt_cor};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enable    <= 1'b0;
            irq_en    <= 1'b0;
            drop_bad  <= 1'b0;
            overrun   <= 1'b0;
            ready_q   <= 1'b0;
            cnt_cor   <= '0;
            cnt_unc   <= '0;
            cnt_drp   <= '0;
            bus.rdata <= '0;
        end else begin
            ready_q <= rx_rst ? 1'b0 : rx_ready;
            if (ctrl_wr) begin
                enable   <= bus.wdata[CTRL_EN];
                irq_en   <= bus.wdata[CTRL_IRQ_EN];
                drop_bad <= bus.wdata[CTRL_DROP_BAD];
            end
            // Clear zeroes first so a frame at the same edge still counts once.
            overrun <= (overrun & ~clear) | ovf;
            cnt_cor <= sat_inc(clear ? 8'h00 : cnt_cor, frame_evt & rx_err_cor);
            cnt_unc <= sat_inc(clear ? 8'h00 : cnt_unc, frame_evt & bad);
            cnt_drp <= sat_inc(clear ? 8'h00 : cnt_drp, (frame_evt & discard) | ovf);
            if (rd_en) bus.rdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Randomized bench for uart_rx_ctrl against a queue-based model of the register map.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_ready = 1'b0;
    logic       rx_err_det = 1'b0;
    logic       rx_err_cor = 1'b0;
    logic       rx_par_err = 1'b0;
    logic       rx_rst;

    uart_rx_ctrl_if bus ();

    uart_rx_ctrl #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .rx_err_det (rx_err_det),
        .rx_err_cor (rx_err_cor),
        .rx_par_err (rx_par_err),
        .rx_rst     (rx_rst),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [10:0] mq[$];
    int  m_cor, m_unc, m_drp;
    bit  m_ovr, m_en, m_ie, m_db;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_cor = 0; m_unc = 0; m_drp = 0;
        m_ovr = 0; m_en = 0; m_ie = 0; m_db = 0;
    endfunction

    function automatic logic [31:0] exp_reg(input logic [1:0] a);
        int s;
        s = mq.size();
        case (a)
            2'd0: return (s == 0) ? 32'h8000_0000 : {21'd0, mq[0]};
            2'd1: return 32'(s * 16 + (m_ovr ? 4 : 0) + (s == DEPTH ? 2 : 0) + (s != 0 ? 1 : 0));
            2'd2: return {29'd0, m_db, m_ie, m_en};
            default: return 32'(m_drp * 65536 + m_unc * 256 + m_cor);
        endcase
    endfunction

    // One bus/frame cycle starting at a negedge; the model is advanced to the
    // state after the following posedge, and outputs are checked at the next negedge.
    task automatic cycle(input string tag, input bit do_rd, input bit do_wr, input logic [1:0] a,
                         input logic [31:0] w, input bit frame, input logic [7:0] d,
                         input bit det, input bit cor, input bit par);
        logic [31:0] exp_rd;
        bit          old_db;
        exp_rd = exp_reg(a);
        bus.sel = do_rd | do_wr; bus.rd = do_rd; bus.wr = do_wr; bus.addr = a; bus.wdata = w;
        if (frame) begin
            rx_data = d; rx_err_det = det; rx_err_cor = cor; rx_par_err = par; rx_ready = 1'b1;
        end
        old_db = m_db;
        if (do_rd && a == 2'd0 && mq.size() > 0) void'(mq.pop_front());
        if (do_wr && a == 2'd2 && w[3]) begin
            m_cor = 0; m_unc = 0; m_drp = 0; m_ovr = 0;
        end
        if (frame) begin
            if (cor) m_cor = sat(m_cor);
            else if (det) m_unc = sat(m_unc);
            if (old_db && det && !cor) m_drp = sat(m_drp);
            else if (mq.size() == DEPTH) begin
                m_ovr = 1; m_drp = sat(m_drp);
            end else mq.push_back({par, cor, det, d});
        end
        if (do_wr && a == 2'd2) begin
            m_en = w[0]; m_ie = w[1]; m_db = w[2];
        end
        @(negedge clk);
        bus.sel = 0; bus.rd = 0; bus.wr = 0;
        rx_ready = 1'b0;
        if (do_rd) chk(tag, bus.rdata, exp_rd);
        chk({tag, "_irq"}, 32'(bus.irq), 32'(m_ie && (mq.size() != 0 || m_ovr)));
        chk({tag, "_rxrst"}, 32'(rx_rst), 32'(!m_en));
        if (frame) @(negedge clk);
    endtask

    task automatic rd_reg(input string tag, input logic [1:0] a);
        cycle(tag, 1, 0, a, '0, 0, '0, 0, 0, 0);
    endtask

    task automatic wr_ctrl(input string tag, input logic [31:0] w);
        cycle(tag, 0, 1, 2'd2, w, 0, '0, 0, 0, 0);
    endtask

    task automatic frame(input string tag, input logic [7:0] d, input bit det, input bit cor, input bit par);
        cycle(tag, 0, 0, 2'd0, '0, 1, d, det, cor, par);
    endtask

    initial begin
        bus.sel = 0; bus.wr = 0; bus.rd = 0; bus.addr = '0; bus.wdata = '0;
        model_reset();
        #1;
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_irq", 32'(bus.irq), 32'h0);
        chk("rst_rxrst", 32'(rx_rst), 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        rd_reg("rst_ctrl", 2'd2);
        rd_reg("rst_status", 2'd1);
        rd_reg("rst_errcnt", 2'd3);
        rd_reg("rst_data", 2'd0);

        wr_ctrl("en", 32'h3);
        frame("f_a5", 8'hA5, 0, 0, 0);
        rd_reg("st_one", 2'd1);
        rd_reg("data_a5", 2'd0);
        rd_reg("st_zero", 2'd1);

        frame("f_3c", 8'h3C, 1, 1, 0);
        rd_reg("data_3c", 2'd0);
        rd_reg("errcnt_cor", 2'd3);

        wr_ctrl("dropbad", 32'h7);
        frame("f_unc", 8'h55, 1, 0, 1);
        rd_reg("st_drop", 2'd1);
        rd_reg("errcnt_drop", 2'd3);
        wr_ctrl("clear", 32'hD);
        rd_reg("errcnt_clr", 2'd3);
        rd_reg("ctrl_after_clr", 2'd2);

        wr_ctrl("en2", 32'h3);
        for (int i = 1; i <= 5; i++) frame("f_fill", 8'(i), 0, 0, 0);
        rd_reg("st_full", 2'd1);
        rd_reg("errcnt_ovf", 2'd3);
        cycle("rd_push_full", 1, 0, 2'd0, '0, 1, 8'h06, 0, 0, 0);
        rd_reg("st_full2", 2'd1);
        rd_reg("errcnt_ovf2", 2'd3);
        for (int i = 0; i < 5; i++) rd_reg("drain", 2'd0);
        rd_reg("drain_empty", 2'd0);

        cycle("rd_push_empty", 1, 0, 2'd0, '0, 1, 8'h9E, 0, 1, 1);
        rd_reg("st_after_rpe", 2'd1);
        cycle("wr_rd_ctrl", 1, 1, 2'd2, 32'h7, 0, '0, 0, 0, 0);
        rd_reg("ctrl_new", 2'd2);
        cycle("wr_ro", 0, 1, 2'd3, 32'hFFFF_FFFF, 0, '0, 0, 0, 0);
        rd_reg("ro_ignored", 2'd3);
        cycle("clear_with_frame", 0, 1, 2'd2, 32'hB, 1, 8'h11, 1, 1, 0);
        rd_reg("errcnt_clr_frame", 2'd3);

        for (int i = 0; i < 300; i++) begin
            frame("f_sat", 8'($urandom), 1, 1, 0);
            rd_reg("sat_pop", 2'd0);
        end
        rd_reg("errcnt_sat", 2'd3);

        for (int i = 0; i < 400; i++) begin
            int unsigned op;
            op = $urandom_range(0, 9);
            if (op <= 4 && m_en)
                frame("r_frame", 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            else if (op <= 7)
                rd_reg("r_read", 2'($urandom));
            else if (op == 8 && m_en)
                cycle("r_rdframe", 1, 0, 2'd0, '0, 1, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            else
                wr_ctrl("r_ctrl", {28'($urandom), 1'($urandom_range(0, 5) == 0), 2'($urandom),
                                   1'($urandom_range(0, 7) != 0)});
        end

        wr_ctrl("en_pre_rst", 32'h3);
        frame("f_pre_rst", 8'h42, 0, 0, 0);
        rd_reg("st_pre_rst", 2'd1);
        rx_data = 8'h77; rx_ready = 1'b1;
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("midrst_rdata", bus.rdata, 32'h0);
        chk("midrst_rxrst", 32'(rx_rst), 32'h1);
        chk("midrst_irq", 32'(bus.irq), 32'h0);
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd_reg("post_rst_status", 2'd1);
        rd_reg("post_rst_data", 2'd0);
        rd_reg("post_rst_ctrl", 2'd2);
        rd_reg("post_rst_errcnt", 2'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
